// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display labs.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low outputs: all ones means nothing lit.
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  typedef logic [1:0] digit_idx_t;

  // Hex-to-segment table, active-low {g,f,e,d,c,b,a}; entry n is HEX_SEG[n].
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // A digit is a leading zero when it and every digit to its left are zero.
  // The rightmost digit is always shown so a zero value still reads "0".
  function automatic logic digit_blanked(input logic [15:0] v, input digit_idx_t d);
    logic res;
    case (d)
      2'd1:    res = (v[15:4] == 12'h000);
      2'd2:    res = (v[15:8] == 8'h00);
      2'd3:    res = (v[15:12] == 4'h0);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Nibble of the 16-bit value belonging to digit d (digit0 = [3:0]).
  function automatic logic [3:0] digit_nibble(input logic [15:0] v, input digit_idx_t d);
    logic [3:0] res;
    case (d)
      2'd1:    res = v[7:4];
      2'd2:    res = v[11:8];
      2'd3:    res = v[15:12];
      default: res = v[3:0];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side signal bundle of the scan driver.
// There is no valid/ready handshake: value/dp_in/blank_lz are level inputs
// sampled only at frame boundaries, and an/seg/dp/frame_tick are registered
// levels/pulses; dbg_idx exposes the digit-select state for observation.
interface seg7_scan_driver_if;
  import seg7_pkg::*;

  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;
  digit_idx_t  dbg_idx;

  // Producer of the display value (counter stage or bench).
  modport master (
    output value, dp_in, blank_lz,
    input  an, seg, dp, frame_tick, dbg_idx
  );

  // The scan driver itself.
  modport slave (
    input  value, dp_in, blank_lz,
    output an, seg, dp, frame_tick, dbg_idx
  );
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode multiplexed display driver with a frame-boundary
// input snapshot, leading-zero blanking and a frame tick.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int PC_W     = 17
) (
  input logic               clk,
  input logic               rst_n,
  seg7_scan_driver_if.slave bus
);

  logic [PC_W-1:0] pc;
  digit_idx_t      idx;
  logic [15:0]     sh_value;
  logic [3:0]      sh_dp;
  logic            sh_blank;
  logic            load_pending;

  logic            tick;
  logic            wrap;
  logic [15:0]     cur_value;
  logic [3:0]      cur_dp;
  logic            cur_blank_lz;
  logic            cur_blank;
  logic [3:0]      cur_nib;
  logic [6:0]      dec_seg;

  logic [3:0]      an_q;
  logic [6:0]      seg_q;
  logic            dp_q;
  logic            frame_tick_q;

  assign tick = (pc == PC_W'(SCAN_DIV - 1));
  assign wrap = tick && (idx == 2'd3);

  // The first slot after reset must already show the value present at
  // release, so during the initial load the live inputs feed the decoder.
  assign cur_value    = load_pending ? bus.value    : sh_value;
  assign cur_dp       = load_pending ? bus.dp_in    : sh_dp;
  assign cur_blank_lz = load_pending ? bus.blank_lz : sh_blank;

  assign cur_nib   = digit_nibble(cur_value, idx);
  assign cur_blank = cur_blank_lz && digit_blanked(cur_value, idx);

  seg7_hex_decoder u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // Prescaler; each wrap advances the digit select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= '0;
      idx <= 2'd0;
    end else if (tick) begin
      pc  <= '0;
      idx <= idx + 2'd1;
    end else begin
      pc  <= pc + 1'b1;
    end
  end

  // Shadow copy of the inputs, refreshed only at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_value     <= 16'h0000;
      sh_dp        <= 4'h0;
      sh_blank     <= 1'b0;
      load_pending <= 1'b1;
    end else begin
      load_pending <= 1'b0;
      if (load_pending || wrap) begin
        sh_value <= bus.value;
        sh_dp    <= bus.dp_in;
        sh_blank <= bus.blank_lz;
      end
    end
  end

  // Registered display outputs for the currently selected digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= wrap;
      if (cur_blank) begin
        an_q  <= AN_OFF;
        seg_q <= SEG_OFF;
        dp_q  <= 1'b1;
      end else begin
        an_q  <= ~(4'b0001 << idx);
        seg_q <= dec_seg;
        dp_q  <= ~cur_dp[idx];
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.dbg_idx    = idx;

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the divided-clock counter stage: takes a 16-bit value (four hex nibbles) plus decimal-point requests and drives a 4-digit multiplexed common-anode seven-segment display.
- Owns its own scan prescaler, digit-select state, a frame-boundary input snapshot (tear-free display), leading-zero blanking and a frame tick.
- Runs on the board system clock, not the divided clock.

Parameters:
- SCAN_DIV, 100000, system-clock cycles each digit is lit; legal range >= 2; bench uses 4.
- PC_W, 17, prescaler width; must satisfy 2^PC_W >= SCAN_DIV.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all state immediately.
- value  input  16  digit3 = [15:12] (leftmost) ... digit0 = [3:0] (rightmost).
- dp_in  input  4  dp_in[i]=1 requests decimal point on digit i.
- blank_lz  input  1  1 = blank leading zeros of the snapshot.
- an  output  4  anode enables, active-low, an[i] = digit i.
- seg  output  7  segments, active-low, seg[0]=a ... seg[6]=g.
- dp  output  1  decimal point, active-low.
- frame_tick  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset (async, rst_n=0): pc=0, idx=0, shadow regs=0, load_pending=1, an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0.
- Prescaler: pc counts 0..SCAN_DIV-1 and wraps to 0. tick = (pc==SCAN_DIV-1).
- On tick, idx advances 0->1->2->3->0. Each digit slot lasts exactly SCAN_DIV cycles.
- Snapshot: value, dp_in and blank_lz are copied into shadow regs on the first clock after reset release (load_pending=1, then cleared) and on every tick where idx==3 (wrap).
  - Inputs are otherwise ignored mid-frame.
  - Display never mixes two values within one frame.
- frame_tick: registered; high for exactly the one cycle after a wrap load. Not asserted for the post-reset load. Period = 4*SCAN_DIV cycles.
- Outputs: registered, 1-cycle latency from idx/shadow. Each cycle, selected digit i = idx:
  - an = all ones except bit i low, unless digit i is blanked.
  - seg = hex decode of shadow nibble i.
  - dp = ~shadow_dp[i].
- Leading-zero blanking (shadow blank_lz=1):
  - digit3 blanked if nib3==0.
  - digit2 blanked if nib3==0 and nib2==0.
  - digit1 blanked if nib3, nib2, nib1 all 0.
  - digit0 never blanked.
  - Blanked slot: an=4'b1111, seg=7'b1111111, dp=1 (dp also suppressed).
- Hex decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset mid-operation: outputs go off with no clock edge. After release, scanning restarts at digit 0 with a fresh snapshot; the first lit slot appears on the first edge after release.
- No X propagation: every register has a reset value.

Decomposition:
- Shared package seg7_pkg:
  - NUM_DIGITS=4.
  - SEG_OFF=7'b1111111, AN_OFF=4'b1111.
  - The 16-entry hex-to-segment constant table.
  - Digit index type (2-bit).
- One combinational sub-module seg7_hex_decoder (4-bit in, 7-bit active-low out), reusable by other display labs.
- Prescaler, idx, snapshot and output registers stay in seg7_scan_driver.

Test Plan:
- Reset held low, clk running -> an=4'b1111, seg=7'b1111111, dp=1, frame_tick=0 on every cycle.
- SCAN_DIV=4, value=16'h0000, blank_lz=0, release reset -> an cycles 1110,1101,1011,0111, 4 cycles each. seg=1000000 throughout. frame_tick pulses once every 16 cycles, aligned with the 0111->1110 transition.
- value=16'h00A1, blank_lz=1 -> digit3/digit2 slots an=1111, seg=1111111. Digit1 slot an=1101, seg=0001000. Digit0 slot an=1110, seg=1111001.
- Tear-free check: value=16'h1111 loaded; change to 16'h8888 during digit1 slot -> digit2/3 slots of the same frame still show 1111001; all slots after next frame_tick show 0000000.
- dp_in=4'b0010, value=16'h1234, blank_lz=0 -> dp=0 only while an=1101; dp=1 in all other slots.
- Drop rst_n mid digit2 slot -> an/seg/dp go off immediately, no clock needed. After release -> first lit slot is an=1110, showing the value present at release.
